seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the 7-segment output path of the tt_um_FSM top. It holds a 4-digit hex value loaded over a valid/ready handshake, with double buffering so a new value appears only at a frame boundary. It drives one digit at a time, with a blanking guard between digits to prevent ghosting. It sits between the FSM core (value producer) and the uo_out/uio_out pins (segments, digit enables).

Parameters:
CLK_DIV, 8, clk cycles per digit slot (guard + show); must be > BLANK_CYCLES
BLANK_CYCLES, 2, cycles per slot with all digit enables off; must be >= 1
NUM_DIGITS, 4, digits per frame; load_data width = 4*NUM_DIGITS

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  scan enable; low forces idle/blank
load_valid  in  1  producer has a new value
load_ready  out  1  shadow buffer empty; transfer occurs when valid&ready at clk edge
load_data  in  16  hex nibbles, nibble 0 = digit 0 (least significant)
load_dp  in  4  decimal point per digit
load_blank_lz  in  1  blank leading zeros for this value
segments  out  7  {g,f,e,d,c,b,a}, active-high
dp  out  1  decimal point of the current digit, active-high
digit_en  out  4  one-hot digit select, active-high
frame_done  out  1  one-cycle pulse on the last cycle of the last slot

Behaviour:
- Single clock; rst is asynchronous and active-high. While rst is high: segments=0, dp=0, digit_en=0, frame_done=0, load_ready=1. Active and shadow registers clear to 0, and state returns to IDLE.
- All outputs are registered. They change on the edge that enters the corresponding state or cycle.
- States:
  - IDLE: enable=0.
  - GUARD: BLANK_CYCLES cycles; digit_en=0, segments=0, dp=0.
  - SHOW: CLK_DIV-BLANK_CYCLES cycles; digit_en=one-hot(idx), segments=decode(nibble idx), dp=dp bit idx.
- Transitions:
  - IDLE -> GUARD(idx=0) on the first edge with enable=1.
  - GUARD -> SHOW when the slot counter reaches BLANK_CYCLES.
  - SHOW -> GUARD(idx+1) at slot end.
  - The last digit wraps to idx=0.
- Frame length is NUM_DIGITS*CLK_DIV cycles.
- enable=0 in any state: next edge goes to IDLE, all display outputs go to 0, and the slot counter and idx reset to 0. Buffers are retained.
- Shadow buffer:
  - Handshake loads data, dp and blank_lz into shadow and sets shadow_full.
  - load_ready = !shadow_full.
  - On the frame_done cycle, if shadow_full: active <= shadow and shadow_full <= 0. The new value is first shown in the next frame (digit 0).
  - No load and transfer can coincide, because ready is low while full.
  - In IDLE with shadow_full, the transfer happens immediately on the next edge.
- Leading-zero blanking (active.blank_lz=1):
  - Digit k>0 has segments forced to 0 when nibble k and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - digit_en and dp are unaffected.
- Decode, 0..F:
  - 0-7: 3F,06,5B,4F,66,6D,7D,07
  - 8-F: 7F,6F,77,7C,39,5E,79,71
- Slot counter width is clog2(CLK_DIV). It wraps with no overflow.

Decomposition:
- seg7_pkg: state enum (IDLE, GUARD, SHOW), the 16-entry decode constant table, and a decode function.
- One sub-module, seg7_hex_decode: combinational nibble -> 7-bit segments. It is instantiated once, muxed by idx, with its output registered in seg7_scan_ctrl.
- Slot counter, idx counter, FSM and buffers live in the top block.

Test Plan:
- Basic scan:
  - Stimulus: reset, load 16'h1234 with dp=0, enable=1.
  - Required: each slot shows 2 guard cycles (digit_en=0), then 6 SHOW cycles.
  - Slot order: digit_en=0001/seg 66, 0010/4F, 0100/5B, 1000/06. frame_done pulses at cycle 32 of the frame.
- Leading-zero blanking:
  - Stimulus: load 16'h0070, blank_lz=1.
  - Required: digits 3,2 seg 00 with digit_en still asserted; digit1=07; digit0=3F. With blank_lz=0 digits 3,2 show 3F.
- Double buffering and backpressure:
  - Stimulus: mid-frame, load 16'hABCD, then immediately present 16'hEF01.
  - Required: first value accepted, load_ready=0 until the edge after frame_done. Display switches to D,C,B,A (5E,39,7C,77) only at the next digit 0. The second value is accepted after that.
- Enable drop:
  - Stimulus: deassert enable in the middle of digit 2 SHOW.
  - Required: next edge digit_en=0, seg=0, dp=0. On re-enable, GUARD for digit 0 first.
- Async reset:
  - Stimulus: assert rst between clock edges mid-SHOW.
  - Required: all outputs 0 and load_ready=1 without a clock edge. After release, the active value is 0 and the display shows 3F on all digits once enabled.
- Decimal point and hex decode:
  - Stimulus: load_dp=4'b0101 with 16'hFE98.
  - Required: dp=1 on digits 0 and 2 only. Segments: digit0=7F, digit1=6F, digit2=79, digit3=71.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and hex-to-segment table for the 7-segment scan path.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // {g,f,e,d,c,b,a}, active-high, indexed by hex nibble
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with guard blanking and a
// double-buffered value that swaps in only at frame boundaries.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 8,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned NUM_DIGITS   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [4*NUM_DIGITS-1:0]   load_data,
  input  logic [NUM_DIGITS-1:0]     load_dp,
  input  logic                      load_blank_lz,
  output logic [6:0]                segments,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      frame_done
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] GUARD_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_t                  state, nstate;
  logic [CW-1:0]           cnt, ncnt;
  logic [IW-1:0]           idx, nidx;

  logic [4*NUM_DIGITS-1:0] act_data, sh_data;
  logic [NUM_DIGITS-1:0]   act_dp, sh_dp;
  logic                    act_blz, sh_blz, sh_full;

  logic [NUM_DIGITS-1:0]   zero_from;
  logic [NUM_DIGITS-1:0]   cur_onehot;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank;
  logic [6:0]              dec_seg;
  logic                    show_n, transfer;

  assign load_ready = ~sh_full;
  assign transfer   = sh_full && (frame_done || state == IDLE);

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nidx   = idx;
    if (!enable) begin
      nstate = IDLE;
      ncnt   = '0;
      nidx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          nstate = GUARD;
          ncnt   = '0;
          nidx   = '0;
        end
        GUARD: begin
          if (cnt == GUARD_LAST) nstate = SHOW;
          ncnt = cnt + CW'(1);
        end
        SHOW: begin
          if (cnt == SLOT_LAST) begin
            nstate = GUARD;
            ncnt   = '0;
            nidx   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
          end else begin
            ncnt = cnt + CW'(1);
          end
        end
        default: begin
          nstate = IDLE;
          ncnt   = '0;
          nidx   = '0;
        end
      endcase
    end
  end

  // Digit k is a leading zero when every nibble from k upward is zero.
  always_comb begin
    zero_from  = '0;
    cur_onehot = '0;
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zero_from[k] = ((act_data >> (4 * k)) == '0);
      if (nidx == IW'(k)) begin
        cur_onehot[k] = 1'b1;
        cur_nib       = act_data[4*k +: 4];
        cur_dp        = act_dp[k];
        cur_blank     = act_blz && (k != 0) && zero_from[k];
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble   (cur_nib),
    .segments (dec_seg)
  );

  assign show_n = (nstate == SHOW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      segments   <= '0;
      dp         <= 1'b0;
      digit_en   <= '0;
      frame_done <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blz    <= 1'b0;
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_blz     <= 1'b0;
      sh_full    <= 1'b0;
    end else begin
      state      <= nstate;
      cnt        <= ncnt;
      idx        <= nidx;
      segments   <= (show_n && !cur_blank) ? dec_seg : '0;
      dp         <= show_n && cur_dp;
      digit_en   <= show_n ? cur_onehot : '0;
      frame_done <= show_n && (nidx == IDX_LAST) && (ncnt == SLOT_LAST);
      if (transfer) begin
        act_data <= sh_data;
        act_dp   <= sh_dp;
        act_blz  <= sh_blz;
        sh_full  <= 1'b0;
      end else if (load_valid && !sh_full) begin
        sh_data  <= load_data;
        sh_dp    <= load_dp;
        sh_blz   <= load_blank_lz;
        sh_full  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: frame-position reference model feeds a queue checked each cycle.
module tb_seg7_scan_ctrl;

  localparam int CD    = 8;
  localparam int BL    = 2;
  localparam int ND    = 4;
  localparam int FRAME = CD * ND;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  load_dp = '0;
  logic        load_blank_lz = 1'b0;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  digit_en;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  seg7_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYCLES(BL), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .load_blank_lz(load_blank_lz),
    .segments(segments), .dp(dp), .digit_en(digit_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] en;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];

  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: t = cycles since the scan started (-1 when idle).
  int          t = -1;
  logic [15:0] a_data = '0, s_data = '0;
  logic [3:0]  a_dp = '0, s_dp = '0;
  logic        a_blz = 1'b0, s_blz = 1'b0, s_full = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    int   slot, ph;
    logic blank;
    logic [15:0] upper;
    if (rst) begin
      t = -1; a_data = '0; a_dp = '0; a_blz = 0;
      s_data = '0; s_dp = '0; s_blz = 0; s_full = 0;
    end else begin
      if (s_full && (t < 0 || (t % FRAME) == FRAME - 1)) begin
        a_data = s_data; a_dp = s_dp; a_blz = s_blz; s_full = 0;
      end else if (load_valid && !s_full) begin
        s_data = load_data; s_dp = load_dp; s_blz = load_blank_lz; s_full = 1;
      end
      t = enable ? t + 1 : -1;
    end
    e = '0;
    e.rdy = !s_full;
    if (t >= 0) begin
      slot = (t / CD) % ND;
      ph   = t % CD;
      if (ph >= BL) begin
        upper = a_data >> (4 * slot);
        blank = a_blz && slot > 0 && upper == 16'd0;
        e.en  = 4'(1 << slot);
        e.seg = blank ? 7'h00 : seg_tab[upper[3:0]];
        e.dp  = a_dp[slot];
        e.fd  = ((t % FRAME) == FRAME - 1);
      end
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({segments, dp, digit_en, frame_done, load_ready} !== e) begin
        errors++;
        $display("FAIL scan @%0t: got seg=%h dp=%b en=%b fd=%b rdy=%b, expected seg=%h dp=%b en=%b fd=%b rdy=%b",
                 $time, segments, dp, digit_en, frame_done, load_ready,
                 e.seg, e.dp, e.en, e.fd, e.rdy);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; holds valid until the handshake completes.
  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic b);
    load_data = d; load_dp = p; load_blank_lz = b; load_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (load_ready) begin
        @(negedge clk);
        load_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    checks++; errors++;
    $display("FAIL load_timeout: load_ready stayed %b, required 1 within 200 cycles", load_ready);
  endtask

  task automatic wait_en(input logic [3:0] target);
    for (int i = 0; i < 200; i++) begin
      if (digit_en == target) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL wait_digit: digit_en=%b, required %b within 200 cycles", digit_en, target);
  endtask

  initial begin
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // Load in idle, then scan
    do_load(16'h1234, 4'b0000, 1'b0);
    enable = 1'b1;
    cycles(2 * FRAME + 5);

    do_load(16'h0070, 4'b0000, 1'b1);
    cycles(2 * FRAME);
    do_load(16'h0070, 4'b0000, 1'b0);
    cycles(2 * FRAME);

    // Double buffering with backpressure
    wait_en(4'b0010);
    do_load(16'hABCD, 4'b0000, 1'b0);
    do_load(16'hEF01, 4'b1000, 1'b0);
    cycles(2 * FRAME);

    // Enable drop mid digit 2
    wait_en(4'b0100);
    cycles(2);
    enable = 1'b0;
    cycles(3);
    enable = 1'b1;
    cycles(FRAME + 4);

    // Async reset mid-SHOW
    wait_en(4'b0010);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({segments, dp, digit_en, frame_done, load_ready} !== {7'h00, 1'b0, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: seg=%h dp=%b en=%b fd=%b rdy=%b, required 00 0 0000 0 1",
               segments, dp, digit_en, frame_done, load_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycles(2 * FRAME);

    do_load(16'hFE98, 4'b0101, 1'b0);
    cycles(2 * FRAME);

    for (int i = 0; i < 1500; i++) begin
      enable        = ($urandom_range(0, 99) < 97);
      load_valid    = ($urandom_range(0, 3) == 0);
      load_data     = 16'($urandom) & masks[$urandom_range(0, 4)];
      load_dp       = 4'($urandom);
      load_blank_lz = 1'($urandom);
      @(negedge clk);
    end
    load_valid = 1'b0;
    cycles(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
